clk_sel_ctrl: RTL

CLK_SEL_CTRL -- requirements
Module: clk_sel_ctrl

---
 rtl/clk_sel_pkg.sv | 18 +
 rtl/clk_sel_ctrl_if.sv | 25 ++
 rtl/clk_alive_det.sv | 52 +++++
 rtl/clk_sel_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/clk_sel_pkg.sv
// Shared definitions for the clock-select controller: FSM states and parameter defaults.
// Combinational only; no latency or backpressure of its own.
package clk_sel_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam int unsigned SETTLE_CYC_DEF    = 8;
    localparam int unsigned ALIVE_WIN_DEF     = 16;
    localparam bit          AUTO_FAILOVER_DEF = 1'b1;

    // Both the settle and idle counters fit their 1..255 parameter ranges.
    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/clk_sel_ctrl_if.sv
// Request handshake and status bundle between a requester and the clock-select controller.
// Handshake is req_valid & req_ready on a rising edge; status outputs are level or 1-cycle pulses.
interface clk_sel_ctrl_if;

    logic       req_valid;
    logic       req_sel;
    logic       req_ready;
    logic       sel;
    logic       busy;
    logic       done;
    logic       err;
    logic       failover;
    logic [1:0] alive;

    modport master (
        output req_valid, req_sel,
        input  req_ready, sel, busy, done, err, failover, alive
    );

    modport slave (
        input  req_valid, req_sel,
        output req_ready, sel, busy, done, err, failover, alive
    );

endinterface

// File: rtl/clk_alive_det.sv
// Liveness detector for one source: syncs its divide-by-2 toggle, flags dead after ALIVE_WIN quiet cycles.
// Edge seen 3 cycles after the toggle; alive drops ALIVE_WIN cycles after the last edge; no backpressure.
module clk_alive_det
    import clk_sel_pkg::*;
#(
    parameter int unsigned ALIVE_WIN = ALIVE_WIN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tgl_i,
    output logic alive_o
);

    localparam logic [CNT_W-1:0] WIN = CNT_W'(ALIVE_WIN);

    logic [2:0]       sync_q;
    logic [CNT_W-1:0] idle_q;
    logic [CNT_W-1:0] idle_d;
    logic             edge_w;

    // Flops 0/1 resolve metastability; flop 2 holds the previous settled level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], tgl_i};
        end
    end

    assign edge_w = sync_q[1] ^ sync_q[2];

    always_comb begin
        idle_d = idle_q;
        if (edge_w) begin
            idle_d = '0;
        end else if (idle_q < WIN) begin
            idle_d = idle_q + 1'b1;
        end
    end

    // Starts saturated so a source is only trusted once it has been seen toggling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= WIN;
        end else begin
            idle_q <= idle_d;
        end
    end

    assign alive_o = (idle_q < WIN);

endmodule

// File: rtl/clk_sel_ctrl.sv
// Clock-select controller: validates and sequences switches of a glitch-free mux select, with auto failover.
// Switch completes SETTLE_CYC+1 edges after handshake; req_ready is low while busy or a failover is pending.
module clk_sel_ctrl
    import clk_sel_pkg::*;
#(
    parameter int unsigned SETTLE_CYC    = SETTLE_CYC_DEF,
    parameter int unsigned ALIVE_WIN     = ALIVE_WIN_DEF,
    parameter bit          AUTO_FAILOVER = AUTO_FAILOVER_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tgl1,
    input  logic          tgl2,
    clk_sel_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    logic [1:0] alive_w;
    logic       fo_cond;

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             tgt_q, tgt_d;
    logic             auto_q, auto_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             fo_q, fo_d;

    clk_alive_det #(.ALIVE_WIN(ALIVE_WIN)) u_det1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .tgl_i   (tgl1),
        .alive_o (alive_w[0])
    );

    clk_alive_det #(.ALIVE_WIN(ALIVE_WIN)) u_det2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .tgl_i   (tgl2),
        .alive_o (alive_w[1])
    );

    // Only fail over toward a live source; with both dead the current select is held.
    assign fo_cond = AUTO_FAILOVER && !alive_w[sel_q] && alive_w[~sel_q];

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tgt_d   = tgt_q;
        auto_d  = auto_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        fo_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fo_cond) begin
                    tgt_d   = ~sel_q;
                    auto_d  = 1'b1;
                    state_d = CHECK;
                end else if (bus.req_valid) begin
                    if (bus.req_sel == sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        tgt_d   = bus.req_sel;
                        auto_d  = 1'b0;
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (alive_w[tgt_q]) begin
                    sel_d   = tgt_q;
                    cnt_d   = SETTLE_LAST;
                    state_d = SETTLE;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (auto_q) begin
                        fo_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            tgt_q   <= 1'b0;
            auto_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            fo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tgt_q   <= tgt_d;
            auto_q  <= auto_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fo_q    <= fo_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE) && !fo_cond;
    assign bus.busy      = (state_q != IDLE);
    assign bus.sel       = sel_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.failover  = fo_q;
    assign bus.alive     = alive_w;

endmodule
